// File: rtl/freq_sweep_ctrl.sv
// Chirp controller: steps a tuning word from f_start to f_stop, holding each value
// for a programmable dwell, with single-shot / auto-repeat modes and abort.
module freq_sweep_ctrl #(
    parameter int PW = 32,
    parameter int CW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic          abort,
    input  logic          repeat_mode,
    input  logic [PW-1:0] f_start,
    input  logic [PW-1:0] f_stop,
    input  logic [PW-1:0] f_step,
    input  logic [CW-1:0] dwell,
    output logic [PW-1:0] freq,
    output logic          busy,
    output logic          done,
    output logic          wrap
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] freq_reg, freq_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          wrap_reg, wrap_next;
    logic [PW-1:0] start_l_reg, start_l_next;
    logic [PW-1:0] stop_l_reg, stop_l_next;
    logic [PW-1:0] step_l_reg, step_l_next;
    logic [CW-1:0] dwell_l_reg, dwell_l_next;
    logic          rep_l_reg, rep_l_next;
    logic          up_l_reg, up_l_next;

    logic          launch;
    logic          expire;
    logic          at_stop;
    logic [PW:0]   up_sum;
    logic [PW:0]   dn_diff;
    logic [PW-1:0] up_val;
    logic [PW-1:0] dn_val;

    assign launch  = (state_reg == IDLE) && start && !abort;
    assign expire  = (cnt_reg == dwell_l_reg - CW'(1));
    assign at_stop = (freq_reg == stop_l_reg);

    // One extra bit on both step directions so carry/borrow clamp to the stop word
    assign up_sum  = {1'b0, freq_reg} + {1'b0, step_l_reg};
    assign dn_diff = {1'b0, freq_reg} - {1'b0, step_l_reg};
    assign up_val  = (up_sum >= {1'b0, stop_l_reg}) ? stop_l_reg : up_sum[PW-1:0];
    assign dn_val  = (dn_diff[PW] || (dn_diff[PW-1:0] <= stop_l_reg)) ? stop_l_reg
                                                                       : dn_diff[PW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            freq_reg    <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            wrap_reg    <= 1'b0;
            start_l_reg <= '0;
            stop_l_reg  <= '0;
            step_l_reg  <= '0;
            dwell_l_reg <= '0;
            rep_l_reg   <= 1'b0;
            up_l_reg    <= 1'b0;
        end else if (en) begin
            state_reg   <= state_next;
            freq_reg    <= freq_next;
            cnt_reg     <= cnt_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            wrap_reg    <= wrap_next;
            start_l_reg <= start_l_next;
            stop_l_reg  <= stop_l_next;
            step_l_reg  <= step_l_next;
            dwell_l_reg <= dwell_l_next;
            rep_l_reg   <= rep_l_next;
            up_l_reg    <= up_l_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (launch) state_next = RUN;
            RUN: begin
                if (abort)
                    state_next = IDLE;
                else if (expire && at_stop && !rep_l_reg)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        freq_next    = freq_reg;
        cnt_next     = cnt_reg;
        done_next    = 1'b0;
        wrap_next    = 1'b0;
        busy_next    = (state_next == RUN);
        start_l_next = start_l_reg;
        stop_l_next  = stop_l_reg;
        step_l_next  = step_l_reg;
        dwell_l_next = dwell_l_reg;
        rep_l_next   = rep_l_reg;
        up_l_next    = up_l_reg;
        case (state_reg)
            IDLE: begin
                if (launch) begin
                    start_l_next = f_start;
                    stop_l_next  = f_stop;
                    step_l_next  = (f_step == '0) ? PW'(1) : f_step;
                    dwell_l_next = (dwell == '0) ? CW'(1) : dwell;
                    rep_l_next   = repeat_mode;
                    up_l_next    = (f_stop >= f_start);
                    freq_next    = f_start;
                    cnt_next     = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_next = '0;
                end else if (expire) begin
                    cnt_next = '0;
                    if (at_stop) begin
                        if (rep_l_reg) begin
                            freq_next = start_l_reg;
                            wrap_next = 1'b1;
                        end else begin
                            done_next = 1'b1;
                        end
                    end else begin
                        freq_next = up_l_reg ? up_val : dn_val;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: ;
        endcase
    end

    assign freq = freq_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign wrap = wrap_reg;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Scoreboard bench for freq_sweep_ctrl: expected per-cycle {freq,busy,done,wrap}
// tuples are queued as each sweep is launched and popped one per clock.
module tb_freq_sweep_ctrl;

    localparam int PW = 32;
    localparam int CW = 24;

    logic          clk;
    logic          rst;
    logic          en;
    logic          start;
    logic          abort;
    logic          repeat_mode;
    logic [PW-1:0] f_start;
    logic [PW-1:0] f_stop;
    logic [PW-1:0] f_step;
    logic [CW-1:0] dwell;
    logic [PW-1:0] freq;
    logic          busy;
    logic          done;
    logic          wrap;

    typedef struct packed {
        logic [PW-1:0] f;
        logic          b;
        logic          d;
        logic          w;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    freq_sweep_ctrl #(.PW(PW), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .start       (start),
        .abort       (abort),
        .repeat_mode (repeat_mode),
        .f_start     (f_start),
        .f_stop      (f_stop),
        .f_step      (f_step),
        .dwell       (dwell),
        .freq        (freq),
        .busy        (busy),
        .done        (done),
        .wrap        (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [PW-1:0] f, input logic b, input logic d,
                        input logic w, input int times);
        exp_t x;
        x.f = f; x.b = b; x.d = d; x.w = w;
        for (int k = 0; k < times; k++) exp_q.push_back(x);
    endtask

    // Presents a configuration with start for one edge; returns just after that edge
    task automatic issue_start(input string tag, input logic [PW-1:0] fs,
                               input logic [PW-1:0] fe, input logic [PW-1:0] st,
                               input logic [CW-1:0] dw, input logic rp);
        @(negedge clk);
        f_start = fs; f_stop = fe; f_step = st; dwell = dw; repeat_mode = rp;
        en = 1'b1; abort = 1'b0; start = 1'b1;
        $display("sweep %s: start=%0h stop=%0h step=%0h dwell=%0d repeat=%0b",
                 tag, fs, fe, st, dw, rp);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; start = 1'b0; abort = 1'b0; repeat_mode = 1'b0;
        f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({freq, busy, done, wrap} !== {32'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_hold: freq=%0d busy=%b done=%b wrap=%b, expected 0/0/0/0",
                     freq, busy, done, wrap);
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({freq, busy, done, wrap} !== {32'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_idle: freq=%0d busy=%b done=%b wrap=%b, expected 0/0/0/0",
                     freq, busy, done, wrap);
        end
        $display("reset: outputs idle after release");
    endtask

    task automatic test_up_sweep;
        int n;
        push(100, 1, 0, 0, 3);
        push(110, 1, 0, 0, 3);
        push(120, 1, 0, 0, 3);
        push(130, 1, 0, 0, 3);
        push(130, 0, 1, 0, 1);
        push(130, 0, 0, 0, 2);
        issue_start("up", 100, 130, 10, 3, 1'b0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            e = exp_q.pop_front();
            n_checks++;
            if ({freq, busy, done, wrap} !== {e.f, e.b, e.d, e.w}) begin
                n_fail++;
                $display("FAIL up_sweep[%0d]: freq=%0d busy=%b done=%b wrap=%b, expected freq=%0d busy=%b done=%b wrap=%b",
                         i, freq, busy, done, wrap, e.f, e.b, e.d, e.w);
            end
        end
    endtask

    task automatic test_down_sweep;
        int n;
        push(130, 1, 0, 0, 1);
        push(118, 1, 0, 0, 1);
        push(106, 1, 0, 0, 1);
        push(100, 1, 0, 0, 1);
        push(100, 0, 1, 0, 1);
        push(100, 0, 0, 0, 2);
        issue_start("down", 130, 100, 12, 1, 1'b0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            e = exp_q.pop_front();
            n_checks++;
            if ({freq, busy, done, wrap} !== {e.f, e.b, e.d, e.w}) begin
                n_fail++;
                $display("FAIL down_sweep[%0d]: freq=%0d busy=%b done=%b wrap=%b, expected freq=%0d busy=%b done=%b wrap=%b",
                         i, freq, busy, done, wrap, e.f, e.b, e.d, e.w);
            end
        end
    endtask

    task automatic test_repeat;
        int n;
        push(0, 1, 0, 0, 2);
        for (int p = 0; p < 3; p++) begin
            if (p > 0) begin
                push(0, 1, 0, 1, 1);
                push(0, 1, 0, 0, 1);
            end
            push(10, 1, 0, 0, 2);
            push(20, 1, 0, 0, 2);
        end
        // Abort lands on the edge that would otherwise wrap: no wrap, freq holds
        push(20, 0, 0, 0, 2);
        issue_start("repeat", 0, 20, 10, 2, 1'b1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            e = exp_q.pop_front();
            n_checks++;
            if ({freq, busy, done, wrap} !== {e.f, e.b, e.d, e.w}) begin
                n_fail++;
                $display("FAIL repeat[%0d]: freq=%0d busy=%b done=%b wrap=%b, expected freq=%0d busy=%b done=%b wrap=%b",
                         i, freq, busy, done, wrap, e.f, e.b, e.d, e.w);
            end
            if (i == n - 3) abort = 1'b1;
            if (i == n - 2) abort = 1'b0;
        end
    endtask

    task automatic test_en_gating;
        int n;
        push(100, 1, 0, 0, 8);
        push(110, 1, 0, 0, 3);
        push(120, 1, 0, 0, 1);
        push(120, 0, 0, 0, 2);
        issue_start("en_gate", 100, 130, 10, 3, 1'b0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            e = exp_q.pop_front();
            n_checks++;
            if ({freq, busy, done, wrap} !== {e.f, e.b, e.d, e.w}) begin
                n_fail++;
                $display("FAIL en_gating[%0d]: freq=%0d busy=%b done=%b wrap=%b, expected freq=%0d busy=%b done=%b wrap=%b",
                         i, freq, busy, done, wrap, e.f, e.b, e.d, e.w);
            end
            if (i == 1)  en = 1'b0;
            if (i == 6)  en = 1'b1;
            if (i == 11) abort = 1'b1;
            if (i == 12) abort = 1'b0;
        end
    endtask

    task automatic test_abort;
        int n;
        push(100, 1, 0, 0, 3);
        push(110, 1, 0, 0, 1);
        push(110, 0, 0, 0, 4);
        issue_start("abort", 100, 130, 10, 3, 1'b0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            e = exp_q.pop_front();
            n_checks++;
            if ({freq, busy, done, wrap} !== {e.f, e.b, e.d, e.w}) begin
                n_fail++;
                $display("FAIL abort[%0d]: freq=%0d busy=%b done=%b wrap=%b, expected freq=%0d busy=%b done=%b wrap=%b",
                         i, freq, busy, done, wrap, e.f, e.b, e.d, e.w);
            end
            if (i == 3) abort = 1'b1;
        end
        abort = 1'b0;
        // start and abort together in IDLE must not launch a sweep
        push(110, 0, 0, 0, 3);
        @(negedge clk);
        f_start = 100; f_stop = 130; f_step = 10; dwell = 3; repeat_mode = 1'b0;
        start = 1'b1; abort = 1'b1;
        $display("sweep start_abort: start and abort asserted together in idle");
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({freq, busy, done, wrap} !== {e.f, e.b, e.d, e.w}) begin
                n_fail++;
                $display("FAIL start_abort[%0d]: freq=%0d busy=%b done=%b wrap=%b, expected freq=%0d busy=%b done=%b wrap=%b",
                         i, freq, busy, done, wrap, e.f, e.b, e.d, e.w);
            end
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_edge_config;
        int n;
        push(5, 1, 0, 0, 1);
        push(6, 1, 0, 0, 1);
        push(7, 1, 0, 0, 1);
        push(7, 0, 1, 0, 1);
        push(7, 0, 0, 0, 1);
        issue_start("zero_step_dwell", 5, 7, 0, 0, 1'b0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            e = exp_q.pop_front();
            n_checks++;
            if ({freq, busy, done, wrap} !== {e.f, e.b, e.d, e.w}) begin
                n_fail++;
                $display("FAIL zero_cfg[%0d]: freq=%0d busy=%b done=%b wrap=%b, expected freq=%0d busy=%b done=%b wrap=%b",
                         i, freq, busy, done, wrap, e.f, e.b, e.d, e.w);
            end
        end
        push(32'hFFFF_FFF0, 1, 0, 0, 2);
        push(32'hFFFF_FFF0, 0, 1, 0, 1);
        push(32'hFFFF_FFF0, 0, 0, 0, 1);
        issue_start("top_of_range", 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h20, 2, 1'b0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            e = exp_q.pop_front();
            n_checks++;
            if ({freq, busy, done, wrap} !== {e.f, e.b, e.d, e.w}) begin
                n_fail++;
                $display("FAIL top_range[%0d]: freq=%0h busy=%b done=%b wrap=%b, expected freq=%0h busy=%b done=%b wrap=%b",
                         i, freq, busy, done, wrap, e.f, e.b, e.d, e.w);
            end
        end
    endtask

    task automatic test_async_reset;
        int n;
        push(100, 1, 0, 0, 3);
        push(110, 1, 0, 0, 3);
        push(120, 1, 0, 0, 1);
        issue_start("pre_reset", 100, 130, 10, 3, 1'b0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            e = exp_q.pop_front();
            n_checks++;
            if ({freq, busy, done, wrap} !== {e.f, e.b, e.d, e.w}) begin
                n_fail++;
                $display("FAIL pre_reset[%0d]: freq=%0d busy=%b done=%b wrap=%b, expected freq=%0d busy=%b done=%b wrap=%b",
                         i, freq, busy, done, wrap, e.f, e.b, e.d, e.w);
            end
        end
        // Assert reset between clock edges; outputs must clear without an edge
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({freq, busy, done, wrap} !== {32'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL async_reset: freq=%0d busy=%b done=%b wrap=%b, expected 0/0/0/0",
                     freq, busy, done, wrap);
        end
        @(negedge clk);
        rst = 1'b0;
        push(100, 1, 0, 0, 3);
        push(110, 1, 0, 0, 1);
        issue_start("post_reset", 100, 130, 10, 3, 1'b0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            e = exp_q.pop_front();
            n_checks++;
            if ({freq, busy, done, wrap} !== {e.f, e.b, e.d, e.w}) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: freq=%0d busy=%b done=%b wrap=%b, expected freq=%0d busy=%b done=%b wrap=%b",
                         i, freq, busy, done, wrap, e.f, e.b, e.d, e.w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_sweep();
        test_down_sweep();
        test_repeat();
        test_en_gating();
        test_abort();
        test_edge_config();
        test_async_reset();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
